// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder plus a carry flop, LSB-first, one bit per clock,
// with valid/ready handshakes on operands and on the {cout,sum} result.

module fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_c;
  assign o_cout = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic [CNT_W-1:0]   r_count;
  logic               w_accept;
  logic               w_shift;
  logic               w_last;
  logic               w_fa_sum;
  logic               w_fa_cout;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_shift  = (r_state == S_SHIFT);
  assign w_last   = w_shift && (r_count == CNT_W'(WIDTH - 1));

  fulladder u_fa (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_c    (r_carry),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state == S_IDLE);
      r_out_valid <= (w_next_state == S_DONE);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next_state = S_SHIFT;
      S_SHIFT: if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default:                w_next_state = S_IDLE;
    endcase
  end

  // Datapath: new sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= cin;
      r_count <= '0;
    end else if (w_shift) begin
      r_sum   <= (r_sum >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));
      r_carry <= w_fa_cout;
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_count <= r_count + CNT_W'(1);
      if (w_last) r_cout <= w_fa_cout;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule
